// File: rtl/lamp_monitor.sv
// Tracks the bound_flasher lamp bar: level, rise/fall direction, turning points and error flags.
// Optional full-bar flash detection is enabled by defining LAMP_MON_FLASH_EN.
module lamp_monitor (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] lamp,
  output logic [4:0]  level,
  output logic        rising,
  output logic        falling,
  output logic        turn,
  output logic [4:0]  peak,
  output logic        seq_done,
  output logic [7:0]  turn_cnt,
  output logic        err_code,
  output logic        err_step,
  output logic        flash
);

  typedef enum logic [1:0] {StIdle, StRise, StFall} state_e;

  state_e      state_q, state_d;
  logic [4:0]  level_q, level_d;
  logic [4:0]  peak_q, peak_d;
  logic [7:0]  turn_cnt_q, turn_cnt_d;
  logic        rising_q, rising_d;
  logic        falling_q, falling_d;
  logic        turn_q, turn_d;
  logic        seq_done_q, seq_done_d;
  logic        err_code_q, err_code_d;
  logic        err_step_q, err_step_d;
  logic        flash_q, flash_d;

  logic              legal;
  logic [4:0]        k;
  logic signed [5:0] delta;
  logic              big_jump;
  logic              flash_jump;

  always_comb begin
    // A thermometer code plus one is a power of two, so the AND is zero.
    legal = (({1'b0, lamp} & ({1'b0, lamp} + 17'd1)) == 17'd0);
    k = 5'd0;
    for (int i = 0; i < 16; i++) begin
      k = k + {4'd0, lamp[i]};
    end
    delta    = $signed({1'b0, k}) - $signed({1'b0, level_q});
    big_jump = (delta > 6'sd1) || (delta < -6'sd1);
`ifdef LAMP_MON_FLASH_EN
    flash_jump = ((level_q == 5'd0) && (k == 5'd16)) || ((level_q == 5'd16) && (k == 5'd0));
`else
    flash_jump = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    peak_d     = peak_q;
    turn_cnt_d = turn_cnt_q;
    err_code_d = err_code_q;
    err_step_d = err_step_q;
    turn_d     = 1'b0;
    seq_done_d = 1'b0;
    flash_d    = 1'b0;

    if (!legal) begin
      err_code_d = 1'b1;
    end else begin
      level_d = k;
      if (flash_jump) begin
        flash_d = 1'b1;
        state_d = StIdle;
      end else begin
        if (big_jump) err_step_d = 1'b1;
        if (delta != 6'sd0) begin
          if (k == 5'd0) begin
            // Any run hitting zero ends the sequence; only a falling run reports completion.
            state_d    = StIdle;
            seq_done_d = (state_q == StFall);
          end else begin
            unique case (state_q)
              StIdle: state_d = (delta > 6'sd0) ? StRise : StFall;
              StRise: begin
                if (delta < 6'sd0) begin
                  state_d = StFall;
                  turn_d  = 1'b1;
                end
              end
              StFall: begin
                if (delta > 6'sd0) begin
                  state_d = StRise;
                  turn_d  = 1'b1;
                end
              end
              default: state_d = StIdle;
            endcase
          end
        end
      end
    end

    if (turn_d) begin
      peak_d = level_q;
      if (turn_cnt_q != 8'hFF) turn_cnt_d = turn_cnt_q + 8'd1;
    end

    rising_d  = (state_d == StRise);
    falling_d = (state_d == StFall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      level_q    <= 5'd0;
      peak_q     <= 5'd0;
      turn_cnt_q <= 8'd0;
      rising_q   <= 1'b0;
      falling_q  <= 1'b0;
      turn_q     <= 1'b0;
      seq_done_q <= 1'b0;
      err_code_q <= 1'b0;
      err_step_q <= 1'b0;
      flash_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      peak_q     <= peak_d;
      turn_cnt_q <= turn_cnt_d;
      rising_q   <= rising_d;
      falling_q  <= falling_d;
      turn_q     <= turn_d;
      seq_done_q <= seq_done_d;
      err_code_q <= err_code_d;
      err_step_q <= err_step_d;
      flash_q    <= flash_d;
    end
  end

  assign level    = level_q;
  assign rising   = rising_q;
  assign falling  = falling_q;
  assign turn     = turn_q;
  assign peak     = peak_q;
  assign seq_done = seq_done_q;
  assign turn_cnt = turn_cnt_q;
  assign err_code = err_code_q;
  assign err_step = err_step_q;
  assign flash    = flash_q;

endmodule

// File: doc/lamp_monitor.md
LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high; sampled on clk rising edge only.
REQ-003 SHALL have: lamp  in  16  lamp bar from bound_flasher; legal value = thermometer code (lamp[k-1:0] lit, k = 0..16).
REQ-004 SHALL have: level  out  5  lamp count k of last legal sample, 0..16.
REQ-005 SHALL have: rising  out  1  FSM in RISE; falling  out  1  FSM in FALL.
REQ-006 SHALL have: turn  out  1  one-cycle pulse on direction reversal.
REQ-007 SHALL have: peak  out  5  level at most recent turning point.
REQ-008 SHALL have: seq_done  out  1  one-cycle pulse when a falling run reaches level 0.
REQ-009 SHALL have: turn_cnt  out  8  turning points since reset, saturating.
REQ-010 SHALL have: err_code  out  1  sticky: non-thermometer lamp seen.
REQ-011 SHALL have: err_step  out  1  sticky: illegal level jump seen.
REQ-012 SHALL have: flash  out  1  one-cycle pulse on full-bar flash transition (see Configuration).

Function
REQ-013 SHALL sample lamp every rising edge; all outputs registered, reflecting the sample one cycle later (latency 1).
REQ-014 Legality test SHALL be: {1'b0,lamp} AND ({1'b0,lamp}+1) == 0; k = popcount(lamp).
REQ-015 Illegal sample SHALL set err_code; level, FSM, peak, lamp_prev SHALL hold; no pulses.
REQ-016 delta = k - level (signed, 6 bits); level SHALL update to k on every legal sample.
REQ-017 |delta| > 1 SHALL set err_step, except flash case per REQ-027.
REQ-018 FSM states IDLE, RISE, FALL; delta == 0 SHALL hold state.
REQ-019 IDLE: delta > 0 -> RISE; delta < 0 -> FALL (no turn pulse).
REQ-020 RISE: delta < 0 -> FALL, turn=1, peak <= old level.
REQ-021 FALL: delta > 0 -> RISE, turn=1, peak <= old level (valley).
REQ-022 FALL and k == 0 -> IDLE, seq_done=1; any state with k == 0 after a jump SHALL also go IDLE (seq_done only from FALL).
REQ-023 turn_cnt SHALL increment on each turn, saturate at 255, never wrap.
REQ-024 turn, seq_done, flash SHALL be single-cycle; may coincide with err_step in the same cycle.

Reset
REQ-025 reset high at edge SHALL force: level=0, state IDLE, rising=falling=0, turn=seq_done=flash=0, peak=0, turn_cnt=0, err_code=err_step=0, lamp_prev=0.
REQ-026 Reset mid-sequence SHALL discard history; first post-reset sample compared against level 0 (e.g. lamp=16'h001F -> err_step).

Configuration
REQ-027 Macro LAMP_MON_FLASH_EN defined: legal jump 0->16 or 16->0 SHALL pulse flash, SHALL NOT set err_step, SHALL force state IDLE, no turn, no seq_done.
REQ-028 Macro undefined: flash SHALL be tied 0; such jumps SHALL set err_step and follow REQ-019/022.

Verification
REQ-029 Ramp 0->5 one step/cycle then 5->0 -> rising for 5 cycles, turn once with peak=5, seq_done on reaching 0, turn_cnt=1, no errors.
REQ-030 Sequence 0->10->5->15->0 (one step/cycle) -> peaks 10,5,15 in order, turn_cnt=3, seq_done once.
REQ-031 lamp=16'h00F5 mid-ramp at level 3 -> err_code=1, level stays 3, FSM unchanged; next lamp 16'h000F continues with delta 1.
REQ-032 Jump 16'h0003 -> 16'h00FF -> err_step=1, level=8, state RISE; err_step held until reset.
REQ-033 Level 16 then lamp=0, then 16'hFFFF: with LAMP_MON_FLASH_EN two flash pulses, err_step=0; without it flash=0, err_step=1.
REQ-034 Reset asserted at level 9 in FALL with turn_cnt=2 -> next cycle all outputs at REQ-025 values; 300 turns -> turn_cnt=255.
